// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory port, redirect input and decode handshake.
// master = fetch unit, slave = surrounding environment (imem, branch unit, decode).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        ready_out;

  modport master (
    output imem_req, imem_addr, instr, pc_out, valid_out,
    input  imem_rdata, redirect_valid, redirect_pc, ready_out
  );

  modport slave (
    input  imem_req, imem_addr, instr, pc_out, valid_out,
    output imem_rdata, redirect_valid, redirect_pc, ready_out
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, 1-cycle imem, small output FIFO, redirect flush.
// Optional FETCH_PERF_CNT_EN adds pop and stall counters (perf_fetched, perf_stall).
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall
`endif
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   pc_reg;
  logic [31:0]   inflight_pc_reg;
  logic          inflight_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem    [FIFO_DEPTH];

  logic [CW:0]   occ;
  logic          issue;
  logic          push;
  logic          pop;
  logic          valid;

  // Occupancy reserves a slot for the in-flight read so a push never overflows.
  assign occ   = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
  assign issue = !reset && !bus.redirect_valid && (occ < DEPTH_L);
  assign push  = inflight_reg && !bus.redirect_valid && !reset;
  assign valid = !reset && (count_reg != '0);
  assign pop   = valid && bus.ready_out && !bus.redirect_valid;

  assign bus.imem_req  = issue;
  assign bus.imem_addr = reset ? RESET_PC : pc_reg;
  assign bus.valid_out = valid;
  assign bus.instr     = valid ? instr_mem[rd_ptr_reg] : '0;
  assign bus.pc_out    = valid ? pc_mem[rd_ptr_reg]    : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
    end else if (bus.redirect_valid) begin
      pc_reg       <= {bus.redirect_pc[31:2], 2'b00};
      inflight_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        pc_reg          <= pc_reg + 32'd4;
        inflight_pc_reg <= pc_reg;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= bus.imem_rdata;
      pc_mem[wr_ptr_reg]    <= inflight_pc_reg;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_reg <= '0;
      perf_stall_reg   <= '0;
    end else begin
      if (pop) perf_fetched_reg <= perf_fetched_reg + 32'd1;
      if (valid && !bus.ready_out) perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_stall   = perf_stall_reg;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a queue-based transaction model of requested-but-unconsumed
// instructions predicts imem_req/imem_addr/valid_out/pc_out/instr every cycle.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus.master),
    .perf_fetched(perf_fetched), .perf_stall(perf_stall));
`else
  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus.master));
`endif

  typedef struct {
    logic [31:0] pc;
    int          rdy;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  int          now;
  int          m_pops, m_stalls;
  int          n_checks, n_fail;
  logic        exp_req, exp_valid;
  logic [31:0] exp_addr, exp_pc, exp_instr;

  // Called one time unit after a posedge; moves to the falling edge and predicts outputs.
  task automatic sample();
    #4;
    if (reset) begin
      exp_req   = 1'b0;
      exp_valid = 1'b0;
      exp_addr  = RST_PC;
    end else begin
      exp_req   = !bus.redirect_valid && (q.size() < DEPTH);
      exp_addr  = m_pc;
      exp_valid = (q.size() > 0) && (q[0].rdy <= now);
    end
    exp_pc    = (q.size() > 0) ? q[0].pc : 32'h0;
    exp_instr = exp_pc ^ KEY;
  endtask

  // Advances the model across the clock edge and plays the 1-cycle instruction memory.
  task automatic tick();
    logic        mreq;
    logic [31:0] maddr;
    ent_t        e;
    mreq  = bus.imem_req;
    maddr = bus.imem_addr;
    if (reset) begin
      q.delete();
      m_pc = RST_PC;
      m_pops = 0;
      m_stalls = 0;
    end else if (bus.redirect_valid) begin
      if (exp_valid && !bus.ready_out) m_stalls++;
      q.delete();
      m_pc = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (exp_valid && bus.ready_out) begin
        void'(q.pop_front());
        m_pops++;
      end
      if (exp_valid && !bus.ready_out) m_stalls++;
      if (exp_req) begin
        e.pc  = m_pc;
        e.rdy = now + 2;
        q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    now++;
    bus.imem_rdata = mreq ? (maddr ^ KEY) : $urandom;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    sample();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) reset = 1'b0;
      bus.ready_out = 1'($urandom);
      sample();
      n_checks++;
      if (bus.valid_out !== 1'b0 || bus.instr !== 32'h0 || bus.pc_out !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d valid=%0b instr=%h pc=%h want 0/0/0", i, bus.valid_out, bus.instr, bus.pc_out);
      end
      n_checks++;
      if (bus.imem_req !== (i == 2) || bus.imem_addr !== RST_PC) begin
        n_fail++;
        $display("FAIL reset_req cyc%0d req=%0b addr=%h want %0b/%h", i, bus.imem_req, bus.imem_addr, (i == 2), RST_PC);
      end
      $display("reset cyc%0d req=%0b addr=%h valid=%0b", i, bus.imem_req, bus.imem_addr, bus.valid_out);
      tick();
    end
  endtask

  task automatic test_stream();
    int first_req, first_valid;
    logic [31:0] first_pc, first_instr;
    apply_reset();
    bus.ready_out = 1'b1;
    first_req = -1;
    first_valid = -1;
    first_pc = 32'hx;
    first_instr = 32'hx;
    for (int i = 0; i < 12; i++) begin
      sample();
      if (first_req < 0 && bus.imem_req === 1'b1) first_req = i;
      if (first_valid < 0 && bus.valid_out === 1'b1) begin
        first_valid = i;
        first_pc = bus.pc_out;
        first_instr = bus.instr;
      end
      n_checks++;
      if (bus.imem_req !== exp_req || (exp_req && bus.imem_addr !== exp_addr)) begin
        n_fail++;
        $display("FAIL stream_req cyc%0d req=%0b addr=%h want %0b/%h", i, bus.imem_req, bus.imem_addr, exp_req, exp_addr);
      end
      n_checks++;
      if (bus.valid_out !== exp_valid || (exp_valid && (bus.pc_out !== exp_pc || bus.instr !== exp_instr))) begin
        n_fail++;
        $display("FAIL stream_out cyc%0d valid=%0b pc=%h instr=%h want %0b/%h/%h", i, bus.valid_out, bus.pc_out, bus.instr, exp_valid, exp_pc, exp_instr);
      end
      $display("stream cyc%0d req=%0b addr=%h valid=%0b pc=%h instr=%h", i, bus.imem_req, bus.imem_addr, bus.valid_out, bus.pc_out, bus.instr);
      tick();
    end
    n_checks++;
    if (first_valid - first_req !== 2 || first_pc !== 32'h0 || first_instr !== 32'hA5A5_0000) begin
      n_fail++;
      $display("FAIL stream_latency got %0d pc=%h instr=%h want 2/00000000/a5a50000", first_valid - first_req, first_pc, first_instr);
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    int popped[$];
    apply_reset();
    bus.ready_out = 1'b0;
    nreq = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) bus.ready_out = 1'b1;
      sample();
      if (i < 8 && bus.imem_req === 1'b1) nreq++;
      if (i >= 8 && bus.valid_out === 1'b1) popped.push_back(int'(bus.pc_out));
      n_checks++;
      if (bus.imem_req !== exp_req || (exp_req && bus.imem_addr !== exp_addr)) begin
        n_fail++;
        $display("FAIL bp_req cyc%0d req=%0b addr=%h want %0b/%h", i, bus.imem_req, bus.imem_addr, exp_req, exp_addr);
      end
      n_checks++;
      if (bus.valid_out !== exp_valid || (exp_valid && (bus.pc_out !== exp_pc || bus.instr !== exp_instr))) begin
        n_fail++;
        $display("FAIL bp_out cyc%0d valid=%0b pc=%h instr=%h want %0b/%h/%h", i, bus.valid_out, bus.pc_out, bus.instr, exp_valid, exp_pc, exp_instr);
      end
      $display("backpressure cyc%0d ready=%0b req=%0b addr=%h valid=%0b pc=%h", i, bus.ready_out, bus.imem_req, bus.imem_addr, bus.valid_out, bus.pc_out);
      tick();
    end
    n_checks++;
    if (nreq !== DEPTH) begin
      n_fail++;
      $display("FAIL bp_req_count got %0d want %0d", nreq, DEPTH);
    end
    n_checks++;
    if (popped.size() < 5 || popped[0] !== 0 || popped[1] !== 4 || popped[2] !== 8 || popped[3] !== 12 || popped[4] !== 16) begin
      n_fail++;
      $display("FAIL bp_pop_order got %p want 0,4,8,12,16...", popped);
    end
  endtask

  task automatic test_redirect();
    int back_cyc, first_addr;
    apply_reset();
    bus.ready_out = 1'b0;
    back_cyc = -1;
    first_addr = -1;
    for (int i = 0; i < 12; i++) begin
      bus.redirect_valid = (i == 4);
      bus.redirect_pc = 32'h0000_0102;
      if (i == 5) bus.ready_out = 1'b1;
      sample();
      if (i > 4 && first_addr < 0 && bus.imem_req === 1'b1) first_addr = int'(bus.imem_addr);
      if (i > 4 && back_cyc < 0 && bus.valid_out === 1'b1 && bus.pc_out === 32'h100) back_cyc = i;
      n_checks++;
      if (bus.imem_req !== exp_req || (exp_req && bus.imem_addr !== exp_addr)) begin
        n_fail++;
        $display("FAIL redir_req cyc%0d req=%0b addr=%h want %0b/%h", i, bus.imem_req, bus.imem_addr, exp_req, exp_addr);
      end
      n_checks++;
      if (bus.valid_out !== exp_valid || (exp_valid && (bus.pc_out !== exp_pc || bus.instr !== exp_instr))) begin
        n_fail++;
        $display("FAIL redir_out cyc%0d valid=%0b pc=%h instr=%h want %0b/%h/%h", i, bus.valid_out, bus.pc_out, bus.instr, exp_valid, exp_pc, exp_instr);
      end
      $display("redirect cyc%0d redir=%0b req=%0b addr=%h valid=%0b pc=%h", i, bus.redirect_valid, bus.imem_req, bus.imem_addr, bus.valid_out, bus.pc_out);
      tick();
    end
    bus.redirect_valid = 1'b0;
    n_checks++;
    if (first_addr !== 32'h100 || back_cyc !== 7) begin
      n_fail++;
      $display("FAIL redir_timing addr=%h back=%0d want 00000100/7", first_addr, back_cyc);
    end
  endtask

  task automatic test_redirect_pop();
    int first_pc;
    logic seen_40;
    apply_reset();
    bus.ready_out = 1'b1;
    first_pc = -1;
    seen_40 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      bus.redirect_valid = (i == 4) || (i == 6) || (i == 7);
      bus.redirect_pc = (i == 4) ? 32'h0000_0200 : (i == 6) ? 32'h0000_0040 : 32'h0000_0080;
      sample();
      if (i > 7 && bus.valid_out === 1'b1) begin
        if (first_pc < 0) first_pc = int'(bus.pc_out);
        if (bus.pc_out === 32'h40) seen_40 = 1'b1;
      end
      n_checks++;
      if (bus.imem_req !== exp_req || (exp_req && bus.imem_addr !== exp_addr)) begin
        n_fail++;
        $display("FAIL rpop_req cyc%0d req=%0b addr=%h want %0b/%h", i, bus.imem_req, bus.imem_addr, exp_req, exp_addr);
      end
      n_checks++;
      if (bus.valid_out !== exp_valid || (exp_valid && (bus.pc_out !== exp_pc || bus.instr !== exp_instr))) begin
        n_fail++;
        $display("FAIL rpop_out cyc%0d valid=%0b pc=%h instr=%h want %0b/%h/%h", i, bus.valid_out, bus.pc_out, bus.instr, exp_valid, exp_pc, exp_instr);
      end
      $display("redirect_pop cyc%0d redir=%0b rpc=%h req=%0b addr=%h valid=%0b pc=%h", i, bus.redirect_valid, bus.redirect_pc, bus.imem_req, bus.imem_addr, bus.valid_out, bus.pc_out);
      tick();
    end
    bus.redirect_valid = 1'b0;
    n_checks++;
    if (first_pc !== 32'h80 || seen_40 !== 1'b0) begin
      n_fail++;
      $display("FAIL rpop_last_wins first=%h seen40=%0b want 00000080/0", first_pc, seen_40);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      bus.ready_out = (i >= 3) && (i != 4);
      reset = (i == 5);
      sample();
      n_checks++;
      if (bus.imem_req !== exp_req || bus.imem_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL mreset_req cyc%0d req=%0b addr=%h want %0b/%h", i, bus.imem_req, bus.imem_addr, exp_req, exp_addr);
      end
      n_checks++;
      if (bus.valid_out !== exp_valid || (exp_valid && (bus.pc_out !== exp_pc || bus.instr !== exp_instr))) begin
        n_fail++;
        $display("FAIL mreset_out cyc%0d valid=%0b pc=%h instr=%h want %0b/%h/%h", i, bus.valid_out, bus.pc_out, bus.instr, exp_valid, exp_pc, exp_instr);
      end
      $display("mid_reset cyc%0d reset=%0b req=%0b addr=%h valid=%0b pc=%h", i, reset, bus.imem_req, bus.imem_addr, bus.valid_out, bus.pc_out);
      tick();
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      bus.ready_out = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc = $urandom;
      if (i > 390) bus.redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 3));
      reset = ($urandom_range(0, 49) == 0);
      sample();
      n_checks++;
      if (bus.imem_req !== exp_req || bus.imem_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL rand_req cyc%0d req=%0b addr=%h want %0b/%h", i, bus.imem_req, bus.imem_addr, exp_req, exp_addr);
      end
      n_checks++;
      if (bus.valid_out !== exp_valid || (exp_valid && (bus.pc_out !== exp_pc || bus.instr !== exp_instr))) begin
        n_fail++;
        $display("FAIL rand_out cyc%0d valid=%0b pc=%h instr=%h want %0b/%h/%h", i, bus.valid_out, bus.pc_out, bus.instr, exp_valid, exp_pc, exp_instr);
      end
      $display("random cyc%0d rst=%0b redir=%0b rdy=%0b req=%0b addr=%h valid=%0b pc=%h", i, reset, bus.redirect_valid, bus.ready_out, bus.imem_req, bus.imem_addr, bus.valid_out, bus.pc_out);
      tick();
    end
    reset = 1'b0;
    bus.redirect_valid = 1'b0;
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      bus.ready_out = 1'($urandom);
      bus.redirect_valid = (i == 20);
      bus.redirect_pc = 32'h0000_0300;
      sample();
      tick();
    end
    bus.redirect_valid = 1'b0;
    sample();
    n_checks++;
    if (perf_fetched !== 32'(m_pops) || perf_stall !== 32'(m_stalls)) begin
      n_fail++;
      $display("FAIL perf_counts fetched=%0d stall=%0d want %0d/%0d", perf_fetched, perf_stall, m_pops, m_stalls);
    end
    $display("perf fetched=%0d stall=%0d", perf_fetched, perf_stall);
    tick();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail = 0;
    now = 0;
    m_pc = RST_PC;
    m_pops = 0;
    m_stalls = 0;
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.ready_out = 1'b0;
    bus.imem_rdata = 32'h0;
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_mid_reset();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
